// File: rtl/quad_word_loader_pkg.sv
// Shared types and constants for the quad word loader.
// Holds the FSM state encoding and lane/count sizing.
package quad_word_loader_pkg;

    localparam int LANES = 4;
    localparam int CNT_W = 2;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } state_e;

endpackage

// File: rtl/quad_word_loader_reg.sv
// N-bit register with synchronous reset and write enable.
// Used once per lane to hold the gathered words.
module quad_word_loader_reg #(
    parameter int N = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    logic [N-1:0] val_q;

    // Capture d when enabled; reset clears to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            val_q <= '0;
        end else if (en) begin
            val_q <= d;
        end
    end

    assign q = val_q;

endmodule

// File: rtl/quad_word_loader.sv
// Gathers four serial words into a group and hands it off.
// Group handoff may overlap with accepting the next first word.
module quad_word_loader
    import quad_word_loader_pkg::*;
#(
    parameter int N = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [N-1:0]     in_data,
    output logic             in_ready,
    input  logic             out_ready,
    output logic             out_valid,
    output logic             load_en,
    output logic [N-1:0]     Out0,
    output logic [N-1:0]     Out1,
    output logic [N-1:0]     Out2,
    output logic [N-1:0]     Out3,
    output logic [CNT_W-1:0] fill_cnt
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LANES-1:0]   lane_we;
    logic [N-1:0]       lane_q [LANES];
    logic               accept;

    assign out_valid = (state_q == ST_FULL);
    assign in_ready  = (state_q == ST_FILL) ? 1'b1 : out_ready;
    assign load_en   = out_valid & out_ready;
    assign accept    = in_valid & in_ready;

    // State and fill counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FILL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, counter and lane write-enable decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lane_we = '0;
        unique case (state_q)
            ST_FILL: begin
                if (clr) begin
                    cnt_d = '0;
                end else if (accept) begin
                    lane_we = LANES'(1) << cnt_q;
                    if (cnt_q == CNT_W'(LANES - 1)) begin
                        state_d = ST_FULL;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_FULL: begin
                if (load_en) begin
                    state_d = ST_FILL;
                    if (in_valid) begin
                        lane_we = LANES'(1);
                        cnt_d   = CNT_W'(1);
                    end else begin
                        cnt_d = '0;
                    end
                end
            end
            default: begin
                state_d = ST_FILL;
                cnt_d   = '0;
            end
        endcase
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        quad_word_loader_reg #(.N(N)) u_reg (
            .clk (clk),
            .rst (rst),
            .en  (lane_we[g]),
            .d   (in_data),
            .q   (lane_q[g])
        );
    end

    assign Out0     = lane_q[0];
    assign Out1     = lane_q[1];
    assign Out2     = lane_q[2];
    assign Out3     = lane_q[3];
    assign fill_cnt = cnt_q;

endmodule

// File: tb/tb_quad_word_loader.sv
// Directed bench for quad_word_loader.
// Inputs change 1ns after the rising edge; outputs checked before the next edge.
module tb_quad_word_loader;

    localparam int N = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic         clr;
    logic         in_valid;
    logic [N-1:0] in_data;
    logic         in_ready;
    logic         out_ready;
    logic         out_valid;
    logic         load_en;
    logic [N-1:0] Out0, Out1, Out2, Out3;
    logic [1:0]   fill_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    quad_word_loader #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .load_en   (load_en),
        .Out0      (Out0),
        .Out1      (Out1),
        .Out2      (Out2),
        .Out3      (Out3),
        .fill_cnt  (fill_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_lanes(input string tag, input int a, input int b,
                             input int c, input int d);
        chk({tag, "_o0"}, 32'(Out0), 32'(a));
        chk({tag, "_o1"}, 32'(Out1), 32'(b));
        chk({tag, "_o2"}, 32'(Out2), 32'(c));
        chk({tag, "_o3"}, 32'(Out3), 32'(d));
    endtask

    task automatic feed(input int w);
        in_valid = 1'b1;
        in_data  = N'(w);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0;
        in_data = '0; out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_ov", 32'(out_valid), 0);
        chk("rst_le", 32'(load_en), 0);
        chk("rst_cnt", 32'(fill_cnt), 0);
        chk("rst_ir", 32'(in_ready), 1);
        chk_lanes("rst", 0, 0, 0, 0);

        // basic group with downstream stalled
        feed(3);
        chk("bg_cnt1", 32'(fill_cnt), 1);
        feed(7);
        feed(11);
        chk("bg_cnt3", 32'(fill_cnt), 3);
        chk("bg_ov_pre", 32'(out_valid), 0);
        feed(19);
        in_valid = 1'b0;
        #1;
        chk("bg_ov", 32'(out_valid), 1);
        chk("bg_ir", 32'(in_ready), 0);
        chk("bg_le0", 32'(load_en), 0);
        chk("bg_cnt0", 32'(fill_cnt), 0);
        chk_lanes("bg", 3, 7, 11, 19);
        out_ready = 1'b1;
        #1;
        chk("bg_le1", 32'(load_en), 1);
        step();
        chk("bg_le_after", 32'(load_en), 0);
        chk("bg_ov_after", 32'(out_valid), 0);

        // back-to-back stream, words 1..8
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = N'(i);
            #1;
            chk($sformatf("b2b_ir%0d", i), 32'(in_ready), 1);
            chk($sformatf("b2b_le%0d", i), 32'(load_en),
                (i == 5) ? 32'd1 : 32'd0);
            if (i == 5) chk_lanes("b2b_g1", 1, 2, 3, 4);
            step();
        end
        in_valid = 1'b0;
        #1;
        chk("b2b_le9", 32'(load_en), 1);
        chk_lanes("b2b_g2", 5, 6, 7, 8);
        step();
        chk("b2b_ov_end", 32'(out_valid), 0);
        chk("b2b_cnt_end", 32'(fill_cnt), 0);

        // backpressure hold
        out_ready = 1'b0;
        feed(9); feed(9); feed(9); feed(9);
        in_valid = 1'b1;
        in_data  = 5'd31;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk($sformatf("bp_ir%0d", i), 32'(in_ready), 0);
            chk($sformatf("bp_ov%0d", i), 32'(out_valid), 1);
            chk($sformatf("bp_cnt%0d", i), 32'(fill_cnt), 0);
            chk_lanes($sformatf("bp%0d", i), 9, 9, 9, 9);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("bp_le", 32'(load_en), 1);
        step();
        out_ready = 1'b0;

        // clr mid-group
        feed(1);
        feed(2);
        chk("clr_cnt2", 32'(fill_cnt), 2);
        clr = 1'b1;
        feed(6);
        clr = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("clr_cnt0", 32'(fill_cnt), 0);
        chk_lanes("clr_keep", 1, 2, 9, 9);
        feed(10); feed(12); feed(14); feed(16);
        in_valid = 1'b0;
        #1;
        chk("clr_ov", 32'(out_valid), 1);
        chk_lanes("clr_grp", 10, 12, 14, 16);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // reset mid-group
        feed(21); feed(22); feed(23);
        chk("rm_cnt3", 32'(fill_cnt), 3);
        rst = 1'b1;
        out_ready = 1'b1;
        feed(24);
        #1;
        chk("rm_cnt", 32'(fill_cnt), 0);
        chk("rm_le", 32'(load_en), 0);
        chk("rm_ov", 32'(out_valid), 0);
        chk_lanes("rm", 0, 0, 0, 0);
        rst = 1'b0;
        out_ready = 1'b0;

        // reset while full
        feed(1); feed(2); feed(3); feed(4);
        in_valid = 1'b0;
        #1;
        chk("rf_ov_pre", 32'(out_valid), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("rf_ov", 32'(out_valid), 0);
        chk("rf_ir", 32'(in_ready), 1);
        chk_lanes("rf", 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
